// File: rtl/mat_seq_pkg.sv
// Shared definitions for the sequential 2x2 matrix multiply controller.
//
// Holds the datapath widths, the FSM state type and small helpers that map a
// multiply step onto operand element indices and accumulator entries.
// Matrix packing: element k = 2*row + col lives at [ELEM_W*k +: ELEM_W].
package mat_seq_pkg;

  localparam int unsigned ELEM_W    = 3;
  localparam int unsigned PROD_W    = 6;
  localparam int unsigned ACC_W     = 7;
  localparam int unsigned N_ENTRIES = 4;
  localparam int unsigned N_STEPS   = 8;

  localparam int unsigned MAT_W   = N_ENTRIES * ELEM_W;  // packed operand width
  localparam int unsigned RES_W   = N_ENTRIES * PROD_W;  // packed result width
  localparam int unsigned STEP_W  = 3;                   // step index 0..7
  localparam int unsigned COUNT_W = 4;                   // product count 0..8
  localparam int unsigned IDX_W   = 2;                   // element/entry index

  // Largest value an output entry can carry; sums above it saturate or wrap.
  localparam logic [ACC_W-1:0] ENTRY_MAX = ACC_W'((2 ** PROD_W) - 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    HOLD
  } state_e;

  // Step s: e = s>>1, t = s&1, i = e>>1, j = e&1.
  // A[i][t] has index 2*i + t, B[t][j] has index 2*t + j.
  function automatic logic [IDX_W-1:0] a_index(input logic [STEP_W-1:0] s);
    return {s[2], s[0]};
  endfunction

  function automatic logic [IDX_W-1:0] b_index(input logic [STEP_W-1:0] s);
    return {s[0], s[1]};
  endfunction

  function automatic logic [IDX_W-1:0] entry_index(input logic [STEP_W-1:0] s);
    return s[2:1];
  endfunction

  function automatic logic [ELEM_W-1:0] get_elem(input logic [MAT_W-1:0] m,
                                                 input logic [IDX_W-1:0] k);
    return m[k*ELEM_W +: ELEM_W];
  endfunction

endpackage

// File: rtl/mat_seq_acc.sv
// One result-entry accumulator for the 2x2 matrix multiply controller.
//
// Ports:
//   clock   rising-edge clock
//   reset   synchronous active-high reset, clears the sum
//   clear   synchronous clear at job accept
//   add_en  add `addend` into the sum this edge
//   addend  product from the external multiplier
//   entry   output entry (saturated or truncated sum)
//   sat     sum exceeds the entry range (saturating build only)
//
// Build option: MAT_SEQ_SATURATE_EN selects saturation to ENTRY_MAX with an
// overflow flag; otherwise the entry is the sum modulo 2**PROD_W and sat is 0.
module mat_seq_acc
  import mat_seq_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              add_en,
  input  logic [PROD_W-1:0] addend,
  output logic [PROD_W-1:0] entry,
  output logic              sat
);

  // Two 3x3-bit products sum to at most 98, so ACC_W bits never wrap.
  logic [ACC_W-1:0] acc_q;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      acc_q <= '0;
    end else if (add_en) begin
      acc_q <= acc_q + {{(ACC_W - PROD_W){1'b0}}, addend};
    end
  end

`ifdef MAT_SEQ_SATURATE_EN
  // The sum only grows until the next clear, so this flag is inherently sticky.
  assign sat   = (acc_q > ENTRY_MAX);
  assign entry = sat ? '1 : acc_q[PROD_W-1:0];
`else
  logic unused_msb;
  assign unused_msb = acc_q[ACC_W-1];
  assign sat        = 1'b0;
  assign entry      = acc_q[PROD_W-1:0];
`endif

endmodule

// File: rtl/mat_seq_controller.sv
// Sequential 2x2 matrix multiply controller driving an external multiplier.
//
// A job is accepted in IDLE, then eight MUL steps each present one pair of
// operand elements to the multiplier and add the returned product into one of
// four entry accumulators. The result is held in HOLD until consumed.
//
// Ports:
//   clock, reset     rising-edge clock, synchronous active-high reset
//   start_valid/ready  job request handshake (ready only in IDLE)
//   matrix_a/b       packed 2x2 operands, element k = 2*row+col at [3k+2:3k]
//   mul_a/mul_b      multiplier operands, zero outside MUL
//   mul_p            combinational product from the external multiplier
//   result_valid/ready result handshake (valid only in HOLD)
//   matrix_result    packed result, entry k at [6k+5:6k]
//   matrix_count     products completed, 0..8
//   busy             FSM is not in IDLE
//   overflow         any entry saturated
//
// Build option: MAT_SEQ_SATURATE_EN enables entry saturation and `overflow`
// (see mat_seq_acc); by default entries wrap and `overflow` stays 0.
module mat_seq_controller
  import mat_seq_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [MAT_W-1:0]   matrix_a,
  input  logic [MAT_W-1:0]   matrix_b,
  output logic [ELEM_W-1:0]  mul_a,
  output logic [ELEM_W-1:0]  mul_b,
  input  logic [PROD_W-1:0]  mul_p,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [RES_W-1:0]   matrix_result,
  output logic [COUNT_W-1:0] matrix_count,
  output logic               busy,
  output logic               overflow
);

  state_e               state_q;
  logic [STEP_W-1:0]    step_q;
  logic [STEP_W-1:0]    step_nxt;
  logic [MAT_W-1:0]     a_q;
  logic [MAT_W-1:0]     b_q;
  logic [COUNT_W-1:0]   count_q;
  logic [ELEM_W-1:0]    mul_a_q;
  logic [ELEM_W-1:0]    mul_b_q;
  logic                 start_ready_q;
  logic                 result_valid_q;
  logic                 busy_q;

  logic                 accept;
  logic [N_ENTRIES-1:0] add_en;
  logic [N_ENTRIES-1:0] entry_sat;

  assign accept   = (state_q == IDLE) && start_valid && start_ready_q;
  assign step_nxt = step_q + STEP_W'(1);

  // Multiplier operands are registered one step ahead so that during step s
  // they already hold A[i][t] and B[t][j]; step 0 is loaded from the inputs
  // at the accept edge since the captured copies are not yet available.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      step_q         <= '0;
      a_q            <= '0;
      b_q            <= '0;
      count_q        <= '0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      start_ready_q  <= 1'b1;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            a_q           <= matrix_a;
            b_q           <= matrix_b;
            step_q        <= '0;
            count_q       <= '0;
            mul_a_q       <= get_elem(matrix_a, a_index(STEP_W'(0)));
            mul_b_q       <= get_elem(matrix_b, b_index(STEP_W'(0)));
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= MUL;
          end
        end
        MUL: begin
          count_q <= count_q + COUNT_W'(1);
          if (step_q == STEP_W'(N_STEPS - 1)) begin
            mul_a_q        <= '0;
            mul_b_q        <= '0;
            result_valid_q <= 1'b1;
            state_q        <= HOLD;
          end else begin
            step_q  <= step_nxt;
            mul_a_q <= get_elem(a_q, a_index(step_nxt));
            mul_b_q <= get_elem(b_q, b_index(step_nxt));
          end
        end
        HOLD: begin
          if (result_valid_q && result_ready) begin
            result_valid_q <= 1'b0;
            start_ready_q  <= 1'b1;
            busy_q         <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: begin
          mul_a_q        <= '0;
          mul_b_q        <= '0;
          result_valid_q <= 1'b0;
          start_ready_q  <= 1'b1;
          busy_q         <= 1'b0;
          state_q        <= IDLE;
        end
      endcase
    end
  end

  // Exactly one accumulator adds per MUL step; two consecutive steps feed it.
  always_comb begin
    add_en = '0;
    if (state_q == MUL) begin
      add_en[entry_index(step_q)] = 1'b1;
    end
  end

  for (genvar e = 0; e < N_ENTRIES; e++) begin : g_acc
    mat_seq_acc u_acc (
      .clock  (clock),
      .reset  (reset),
      .clear  (accept),
      .add_en (add_en[e]),
      .addend (mul_p),
      .entry  (matrix_result[e*PROD_W +: PROD_W]),
      .sat    (entry_sat[e])
    );
  end

  assign start_ready  = start_ready_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign matrix_count = count_q;
  assign overflow     = |entry_sat;

endmodule

// File: tb/tb_mat_seq_controller.sv
// Self-checking bench for mat_seq_controller with a behavioural multiplier
// and a scoreboard of expected results.
module tb_mat_seq_controller;

  typedef struct packed {
    logic [23:0] res;
    logic        ovf;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic [11:0] matrix_a;
  logic [11:0] matrix_b;
  logic [2:0]  mul_a;
  logic [2:0]  mul_b;
  logic [5:0]  mul_p;
  logic        result_valid;
  logic        result_ready;
  logic [23:0] matrix_result;
  logic [3:0]  matrix_count;
  logic        busy;
  logic        overflow;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  assign mul_p = {3'b000, mul_a} * {3'b000, mul_b};

  mat_seq_controller dut (
    .clock         (clock),
    .reset         (reset),
    .start_valid   (start_valid),
    .start_ready   (start_ready),
    .matrix_a      (matrix_a),
    .matrix_b      (matrix_b),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_p         (mul_p),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .matrix_result (matrix_result),
    .matrix_count  (matrix_count),
    .busy          (busy),
    .overflow      (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Plain 2x2 matrix product, independent of the step ordering.
  function automatic exp_t model(input logic [11:0] a, input logic [11:0] b);
    exp_t r;
    int   s;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = int'(a[(2*i)*3 +: 3]) * int'(b[j*3 +: 3])
          + int'(a[(2*i+1)*3 +: 3]) * int'(b[(2+j)*3 +: 3]);
`ifdef MAT_SEQ_SATURATE_EN
        if (s > 63) begin
          s     = 63;
          r.ovf = 1'b1;
        end
`endif
        r.res[(2*i+j)*6 +: 6] = 6'(s);
      end
    end
    return r;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_start_ready"}, 32'(start_ready), 32'(1));
    check({tag, "_result_valid"}, 32'(result_valid), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_mul_ops"}, 32'({mul_a, mul_b}), 32'(0));
  endtask

  // One job with optional operand change after accept and HOLD backpressure.
  task automatic run_job(input logic [11:0] a, input logic [11:0] b,
                         input int hold_cycles, input bit zap_a);
    exp_t e;
    int   waited;
    int   i;
    int   j;
    int   t;
    matrix_a     = a;
    matrix_b     = b;
    start_valid  = 1'b1;
    result_ready = 1'b0;
    sb.push_back(model(a, b));
    tick();
    start_valid = 1'b0;
    if (zap_a) matrix_a = 12'h000;
    check("accept_busy", 32'(busy), 32'(1));
    check("accept_start_ready", 32'(start_ready), 32'(0));
    for (int s = 0; s < 8; s++) begin
      t = s & 1;
      i = (s >> 1) >> 1;
      j = (s >> 1) & 1;
      check("mul_ops", 32'({mul_a, mul_b}),
            32'({a[(2*i+t)*3 +: 3], b[(2*t+j)*3 +: 3]}));
      check("count_step", 32'(matrix_count), 32'(s));
      tick();
    end
    waited = 0;
    while (!result_valid && waited < 8) begin
      tick();
      waited++;
    end
    check("latency", 32'(8 + waited), 32'(8));
    e = sb.pop_front();
    check("result", 32'(matrix_result), 32'(e.res));
    check("overflow", 32'(overflow), 32'(e.ovf));
    check("count_final", 32'(matrix_count), 32'(8));
    check("hold_mul_ops", 32'({mul_a, mul_b}), 32'(0));
    for (int c = 0; c < hold_cycles; c++) begin
      start_valid = (c == 1);
      tick();
      check("bp_valid", 32'(result_valid), 32'(1));
      check("bp_start_ready", 32'(start_ready), 32'(0));
      check("bp_busy", 32'(busy), 32'(1));
      check("bp_result", 32'(matrix_result), 32'(e.res));
      check("bp_count", 32'(matrix_count), 32'(8));
      check("bp_overflow", 32'(overflow), 32'(e.ovf));
    end
    start_valid  = 1'b0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check_idle("release");
  endtask

  initial begin
    int          acc_cyc[$];
    int          n_acc;
    exp_t        e;
    logic [11:0] ra;
    logic [11:0] rb;

    reset        = 1'b1;
    start_valid  = 1'b0;
    result_ready = 1'b0;
    matrix_a     = '0;
    matrix_b     = '0;
    tick();
    tick();
    check_idle("reset");
    check("reset_overflow", 32'(overflow), 32'(0));
    check("reset_result", 32'(matrix_result), 32'(0));
    check("reset_count", 32'(matrix_count), 32'(0));
    reset = 1'b0;
    tick();

    // Identity, all-sevens, operand change after accept, backpressure.
    run_job(12'h201, 12'h8D1, 0, 1'b0);
    run_job(12'hFFF, 12'hFFF, 0, 1'b0);
    run_job(12'h201, 12'h8D1, 0, 1'b1);
    run_job(12'h5A3, 12'h3C7, 5, 1'b0);
    for (int k = 0; k < 4; k++) begin
      ra = 12'($urandom());
      rb = 12'($urandom());
      run_job(ra, rb, k, 1'b0);
    end

    // Reset at step 3, together with a start request.
    matrix_a    = 12'hFFF;
    matrix_b    = 12'hFFF;
    start_valid = 1'b1;
    sb.push_back(model(matrix_a, matrix_b));
    tick();
    start_valid = 1'b0;
    tick();
    tick();
    tick();
    check("pre_reset_count", 32'(matrix_count), 32'(3));
    reset       = 1'b1;
    start_valid = 1'b1;
    tick();
    sb.delete();
    start_valid = 1'b0;
    check_idle("midop_reset");
    check("midop_count", 32'(matrix_count), 32'(0));
    check("midop_result", 32'(matrix_result), 32'(0));
    reset = 1'b0;
    tick();
    check_idle("after_reset");

    // Back-to-back with start_valid held high; operands change after accepts.
    matrix_a     = 12'h201;
    matrix_b     = 12'h8D1;
    start_valid  = 1'b1;
    result_ready = 1'b1;
    for (int cyc = 0; cyc < 35; cyc++) begin
      n_acc = 0;
      if (start_ready && start_valid) begin
        acc_cyc.push_back(cyc);
        sb.push_back(model(matrix_a, matrix_b));
        n_acc = 1;
      end
      if (result_valid && result_ready) begin
        e = sb.pop_front();
        check("b2b_result", 32'(matrix_result), 32'(e.res));
        check("b2b_overflow", 32'(overflow), 32'(e.ovf));
      end
      tick();
      if (n_acc != 0) begin
        matrix_a = 12'($urandom());
        matrix_b = 12'($urandom());
      end
    end
    start_valid = 1'b0;
    for (int w = 0; w < 20 && (busy || sb.size() != 0); w++) begin
      if (result_valid && result_ready) begin
        e = sb.pop_front();
        check("b2b_result", 32'(matrix_result), 32'(e.res));
        check("b2b_overflow", 32'(overflow), 32'(e.ovf));
      end
      tick();
    end
    check("b2b_accepts", 32'(acc_cyc.size()), 32'(4));
    for (int k = 1; k < acc_cyc.size(); k++) begin
      check("b2b_gap", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'(10));
    end
    check("sb_drained", 32'(sb.size()), 32'(0));
    result_ready = 1'b0;
    check_idle("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
